// File: rtl/vga_pkg.sv
// Shared VGA timing and frame-buffer geometry for the capture, Sobel and reader blocks.
package vga_pkg;

    // 640x480@60 timing, in pixels / lines
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Stored image and its placement on screen (centred)
    localparam int unsigned IMG_W = 150;
    localparam int unsigned IMG_H = 150;
    localparam int unsigned X0    = 245;
    localparam int unsigned Y0    = 165;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned COL_W  = 8;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [COL_W-1:0]  col_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Counter-width copies of the boundaries so comparisons stay width-matched
    localparam cnt_t H_LAST      = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST      = cnt_t'(V_TOTAL - 1);
    localparam cnt_t HS_START    = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END      = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START    = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END      = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam cnt_t WIN_X_START = cnt_t'(X0);
    localparam cnt_t WIN_X_END   = cnt_t'(X0 + IMG_W);
    localparam cnt_t WIN_X_LAST  = cnt_t'(X0 + IMG_W - 1);
    localparam cnt_t WIN_Y_START = cnt_t'(Y0);
    localparam cnt_t WIN_Y_END   = cnt_t'(Y0 + IMG_H);
    localparam addr_t ROW_STEP   = addr_t'(IMG_W);

    // Keep the top four bits of each RGB565 field
    function automatic rgb_t rgb565_to_rgb444(input logic [15:0] px);
        rgb_t c;
        c.r = px[15:12];
        c.g = px[10:7];
        c.b = px[4:1];
        return c;
    endfunction

endpackage

// File: rtl/buffer_frame_reader_if.sv
// Buffer read ports plus VGA pins, as seen by the frame reader.
interface buffer_frame_reader_if;
    logic               sel;
    logic [15:0]        d_out_a;
    logic               d_out_b;
    vga_pkg::addr_t     r_addr_a;
    vga_pkg::addr_t     r_addr_b;
    logic               hsync;
    logic               vsync;
    logic [3:0]         vga_r;
    logic [3:0]         vga_g;
    logic [3:0]         vga_b;
    logic               frame_start;

    // Reader side
    modport master (
        input  sel,
        input  d_out_a,
        input  d_out_b,
        output r_addr_a,
        output r_addr_b,
        output hsync,
        output vsync,
        output vga_r,
        output vga_g,
        output vga_b,
        output frame_start
    );

    // Buffer / board side
    modport slave (
        output sel,
        output d_out_a,
        output d_out_b,
        input  r_addr_a,
        input  r_addr_b,
        input  hsync,
        input  vsync,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 25 MHz pixel strobe from the 50 MHz clock, scan counters, raw syncs and frame marker.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    output logic o_pix_en,
    output cnt_t o_h_cnt,
    output cnt_t o_v_cnt,
    output logic o_hsync_raw,
    output logic o_vsync_raw,
    output logic o_frame_start,
    output logic o_frame_wrap
);

    logic r_pix_en;
    cnt_t r_h_cnt;
    cnt_t r_v_cnt;
    logic w_line_end;
    cnt_t w_h_cnt_nxt;
    cnt_t w_v_cnt_nxt;

    // Next counter values; counters only move on pixel-enable cycles
    always_comb begin
        w_line_end  = r_pix_en && (r_h_cnt == H_LAST);
        w_h_cnt_nxt = r_h_cnt;
        w_v_cnt_nxt = r_v_cnt;
        if (r_pix_en) begin
            w_h_cnt_nxt = (r_h_cnt == H_LAST) ? '0 : r_h_cnt + cnt_t'(1);
            if (r_h_cnt == H_LAST) begin
                w_v_cnt_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + cnt_t'(1);
            end
        end
    end

    // Strobe and counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pix_en <= 1'b0;
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
        end else begin
            r_pix_en <= ~r_pix_en;
            r_h_cnt  <= w_h_cnt_nxt;
            r_v_cnt  <= w_v_cnt_nxt;
        end
    end

    // Undelayed sync, frame marker and end-of-frame flag decoded from the counters
    always_comb begin
        o_hsync_raw   = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
        o_vsync_raw   = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
        o_frame_start = r_pix_en && (r_h_cnt == '0) && (r_v_cnt == '0);
        o_frame_wrap  = w_line_end && (r_v_cnt == V_LAST);
    end

    assign o_pix_en = r_pix_en;
    assign o_h_cnt  = r_h_cnt;
    assign o_v_cnt  = r_v_cnt;

endmodule

// File: rtl/buffer_frame_reader.sv
// Scans the 150x150 frame buffer and drives it as a centred window on 640x480 VGA.
module buffer_frame_reader
    import vga_pkg::*;
(
    input  logic                  r_clk,
    input  logic                  rst,
    buffer_frame_reader_if.master bus
);

    logic  w_pix_en;
    cnt_t  w_h_cnt;
    cnt_t  w_v_cnt;
    logic  w_hs_raw;
    logic  w_vs_raw;
    logic  w_frame_start;
    logic  w_frame_wrap;
    logic  w_in_win;
    logic  w_win_last;
    rgb_t  w_rgb_nxt;

    col_t  r_col;
    addr_t r_row_base;
    addr_t r_addr;
    logic  r_in_win_d1;
    logic  r_hs_d1;
    logic  r_vs_d1;
    logic  r_sel_q;
    rgb_t  r_rgb;
    logic  r_hsync;
    logic  r_vsync;

    vga_timing_gen u_timing (
        .i_clk         (r_clk),
        .i_rst         (rst),
        .o_pix_en      (w_pix_en),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_hsync_raw   (w_hs_raw),
        .o_vsync_raw   (w_vs_raw),
        .o_frame_start (w_frame_start),
        .o_frame_wrap  (w_frame_wrap)
    );

    // Window membership at the counter stage
    always_comb begin
        w_in_win   = (w_h_cnt >= WIN_X_START) && (w_h_cnt < WIN_X_END) &&
                     (w_v_cnt >= WIN_Y_START) && (w_v_cnt < WIN_Y_END);
        w_win_last = w_in_win && (w_h_cnt == WIN_X_LAST);
    end

    // Column / row-base walk: row_base steps by IMG_W after each window line, no multiplier
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            r_col      <= '0;
            r_row_base <= '0;
        end else if (w_pix_en) begin
            if (w_frame_wrap) begin
                r_col      <= '0;
                r_row_base <= '0;
            end else if (w_win_last) begin
                r_col      <= '0;
                r_row_base <= r_row_base + ROW_STEP;
            end else if (w_in_win) begin
                r_col      <= r_col + col_t'(1);
            end
        end
    end

    // Stage 1: address (held outside the window), window flag and sync
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_in_win_d1 <= 1'b0;
            r_hs_d1     <= 1'b1;
            r_vs_d1     <= 1'b1;
        end else if (w_pix_en) begin
            if (w_in_win) begin
                r_addr <= r_row_base + addr_t'(r_col);
            end
            r_in_win_d1 <= w_in_win;
            r_hs_d1     <= w_hs_raw;
            r_vs_d1     <= w_vs_raw;
        end
    end

    // Source select only changes at frame start so a frame never mixes sources
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            r_sel_q <= 1'b0;
        end else if (w_frame_start) begin
            r_sel_q <= bus.sel;
        end
    end

    // Colour decode of the buffer data returned for the stage-1 address
    always_comb begin
        w_rgb_nxt = '0;
        if (r_in_win_d1) begin
            if (r_sel_q) begin
                w_rgb_nxt = bus.d_out_b ? '1 : '0;
            end else begin
                w_rgb_nxt = rgb565_to_rgb444(bus.d_out_a);
            end
        end
    end

    // Stage 2: colour and sync registered together so they stay aligned
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            r_rgb   <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (w_pix_en) begin
            r_rgb   <= w_rgb_nxt;
            r_hsync <= r_hs_d1;
            r_vsync <= r_vs_d1;
        end
    end

    assign bus.r_addr_a    = r_addr;
    assign bus.r_addr_b    = r_addr;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.vga_r       = r_rgb.r;
    assign bus.vga_g       = r_rgb.g;
    assign bus.vga_b       = r_rgb.b;
    assign bus.frame_start = w_frame_start;

endmodule

// File: tb/tb_buffer_frame_reader.sv
// Directed bench for buffer_frame_reader. Cycle k counts r_clk edges after reset release;
// pixel p = v*800+h is on the counters in cycles 2p/2p+1, its address in 2p+2/2p+3 and its
// colour/sync on the outputs in 2p+4/2p+5.
module tb_buffer_frame_reader;

    logic        r_clk = 1'b0;
    logic        rst   = 1'b1;
    int unsigned cyc;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [11:0] rgb;

    buffer_frame_reader_if bus ();

    buffer_frame_reader dut (
        .r_clk (r_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #10 r_clk = ~r_clk;

    always @(posedge r_clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Registered buffer model: distinct word at address 0, red elsewhere; edge bit clear at 1
    always @(posedge r_clk) begin
        bus.d_out_a <= (bus.r_addr_a == 15'd0) ? 16'hA5A5 : 16'hF800;
        bus.d_out_b <= (bus.r_addr_b != 15'd1);
    end

    assign rgb = {bus.vga_r, bus.vga_g, bus.vga_b};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int unsigned k);
        while (cyc < k) @(negedge r_clk);
    endtask

    initial begin
        #40_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sel = 1'b0;
        repeat (3) @(negedge r_clk);
        rst = 1'b0;

        // Reset mid-line while hsync output is low (line 0 output low in cycles 1316..1507)
        wait_cyc(1400);
        check_eq("pre_rst_hsync", bus.hsync, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("rst_hsync", bus.hsync, 1'b1);
        check_eq("rst_vsync", bus.vsync, 1'b1);
        check_eq("rst_rgb", rgb, 12'h000);
        check_eq("rst_addr_a", bus.r_addr_a, 15'd0);
        check_eq("rst_addr_b", bus.r_addr_b, 15'd0);
        check_eq("rst_fs", bus.frame_start, 1'b0);
        repeat (5) @(negedge r_clk);
        check_eq("rst_hold_hsync", bus.hsync, 1'b1);
        check_eq("rst_hold_addr", bus.r_addr_a, 15'd0);
        rst = 1'b0;

        // First frame_start in the cycle after the first post-release edge
        check_eq("fs_c0", bus.frame_start, 1'b0);
        wait_cyc(1);    check_eq("fs_c1", bus.frame_start, 1'b1);
        wait_cyc(2);    check_eq("fs_c2", bus.frame_start, 1'b0);

        // hsync: falls at 2*656+4, rises at 2*752+4, next fall one line (1600) later
        wait_cyc(1315); check_eq("hs_pre_fall", bus.hsync, 1'b1);
        wait_cyc(1316); check_eq("hs_fall", bus.hsync, 1'b0);
        wait_cyc(1507); check_eq("hs_low_end", bus.hsync, 1'b0);
        wait_cyc(1508); check_eq("hs_rise", bus.hsync, 1'b1);
        wait_cyc(2915); check_eq("hs_pre_fall2", bus.hsync, 1'b1);
        wait_cyc(2916); check_eq("hs_fall2", bus.hsync, 1'b0);

        // Switch to edge mode mid-frame; must not take effect until the next frame
        wait_cyc(100000);
        bus.sel = 1'b1;

        // Frame 0 window, port A still shown
        wait_cyc(240605);  check_eq("rgb_above_win", rgb, 12'h000);
        wait_cyc(264493);  check_eq("addr_x0y0", bus.r_addr_a, 15'd0);
                           check_eq("rgb_left_of_win", rgb, 12'h000);
        wait_cyc(264494);  check_eq("lat_rgb", rgb, 12'hAB2);
                           check_eq("lat_hsync", bus.hsync, 1'b1);
                           check_eq("lat_vsync", bus.vsync, 1'b1);
        wait_cyc(264495);  check_eq("addr_x1y0", bus.r_addr_a, 15'd1);
        wait_cyc(264497);  check_eq("rgb_red_x1", rgb, 12'hF00);
        wait_cyc(264791);  check_eq("addr_x149y0", bus.r_addr_a, 15'd149);
        wait_cyc(264793);  check_eq("addr_hold", bus.r_addr_a, 15'd149);
        wait_cyc(266093);  check_eq("addr_x0y1", bus.r_addr_a, 15'd150);
                           check_eq("addr_b_x0y1", bus.r_addr_b, 15'd150);
        wait_cyc(320493);  check_eq("rgb_left_y35", rgb, 12'h000);
        wait_cyc(320793);  check_eq("rgb_red_x149", rgb, 12'hF00);
        wait_cyc(320795);  check_eq("rgb_right_y35", rgb, 12'h000);
        wait_cyc(503191);  check_eq("addr_last", bus.r_addr_a, 15'd22499);
        wait_cyc(503193);  check_eq("rgb_red_last", rgb, 12'hF00);
        wait_cyc(504605);  check_eq("rgb_below_win", rgb, 12'h000);

        // vsync: falls at 2*(490*800)+4, low for 3200
        wait_cyc(784003);  check_eq("vs_pre_fall", bus.vsync, 1'b1);
        wait_cyc(784004);  check_eq("vs_fall", bus.vsync, 1'b0);
        wait_cyc(787203);  check_eq("vs_low_end", bus.vsync, 1'b0);
        wait_cyc(787204);  check_eq("vs_rise", bus.vsync, 1'b1);

        // Frame 1 starts at pixel 420000
        wait_cyc(840000);  check_eq("fs1_pre", bus.frame_start, 1'b0);
        wait_cyc(840001);  check_eq("fs1", bus.frame_start, 1'b1);
        wait_cyc(840002);  check_eq("fs1_post", bus.frame_start, 1'b0);

        // Back to camera mid-frame 1; frame 1 must keep showing edges
        wait_cyc(900000);
        bus.sel = 1'b0;

        wait_cyc(1104491); check_eq("addr_hold_f1", bus.r_addr_a, 15'd22499);
        wait_cyc(1104493); check_eq("addr_f1_first", bus.r_addr_a, 15'd0);
        wait_cyc(1104494); check_eq("edge_rgb_a0", rgb, 12'hFFF);
        wait_cyc(1104497); check_eq("edge_rgb_a1", rgb, 12'h000);
        wait_cyc(1104499); check_eq("edge_rgb_a2", rgb, 12'hFFF);

        // vsync period: 525 lines = 840000 r_clk
        wait_cyc(1624003); check_eq("vs_pre_fall2", bus.vsync, 1'b1);
        wait_cyc(1624004); check_eq("vs_fall2", bus.vsync, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
